// File: rtl/vector_control_sequencer.sv
// +--------------------------------------------------------------------------+
// | vector_control_sequencer: registered pipeline control with multi-beat    |
// | vector expansion. Optional tail masking via `VEC_TAIL_MASK_EN.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vector_control_sequencer #(
  parameter int OPCODE_W  = 6,
  parameter int FUNC_W    = 3,
  parameter int REG_W     = 5,
  parameter int PC_REG    = 15,
  parameter int LANES     = 4,
  parameter int VEC_ELEMS = 16,
  localparam int BEATS    = VEC_ELEMS / LANES,
  localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int VLW      = $clog2(VEC_ELEMS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [FUNC_W-1:0]   Func,
  input  logic [REG_W-1:0]    Rd,
`ifdef VEC_TAIL_MASK_EN
  input  logic [VLW-1:0]      vlen,
`endif
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  output logic                RegWrite,
  output logic                RegWriteV,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                ALUSrc,
  output logic                Branch,
  output logic                PCSrc,
  output logic [FUNC_W-1:0]   ALUControl,
  output logic [BW-1:0]       BeatIdx,
  output logic                LastBeat,
  output logic [LANES-1:0]    LaneMask,
  output logic                busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    VSEQ = 1'b1
  } state_t;

  state_t             state_q;
  logic [BW-1:0]      beat_q;
  logic [BW-1:0]      last_q;
  logic [VLW-1:0]     vlen_q;
  logic               out_valid_q;
  logic               reg_write_q;
  logic               reg_write_v_q;
  logic               mem_write_q;
  logic               mem_to_reg_q;
  logic               alu_src_q;
  logic               branch_q;
  logic               pc_src_q;
  logic [FUNC_W-1:0]  alu_ctrl_q;
  logic [BW-1:0]      beat_idx_q;
  logic               last_beat_q;
  logic [LANES-1:0]   lane_mask_q;
  logic               busy_q;

  logic               rw_d;
  logic               rwv_d;
  logic               mw_d;
  logic               m2r_d;
  logic               alusrc_d;
  logic               br_d;
  logic               pcsrc_d;
  logic               vec_d;
  logic [FUNC_W-1:0]  alu_d;
  logic [VLW-1:0]     vlen_d;
  logic [BW-1:0]      last_d;
  logic [BW-1:0]      beat_d;
  logic               accept;
  logic               unused_opcode;

  function automatic logic [LANES-1:0] lane_mask(input int beat, input int len);
    logic [LANES-1:0] m;
    for (int l = 0; l < LANES; l++) begin
      m[l] = ((beat * LANES) + l) < len;
    end
    return m;
  endfunction

  function automatic logic [BW-1:0] last_beat_of(input int len);
    return BW'((len - 1) / LANES);
  endfunction

  always_comb begin
    rw_d     = 1'b0;
    rwv_d    = 1'b0;
    mw_d     = 1'b0;
    m2r_d    = 1'b0;
    alusrc_d = 1'b0;
    br_d     = 1'b0;
    vec_d    = 1'b0;
    alu_d    = '0;
    case (Opcode[5:4])
      2'b00: begin
        rw_d  = 1'b1;
        alu_d = Func;
      end
      2'b01: begin
        alusrc_d = 1'b1;
        if (!Opcode[0]) begin
          rw_d  = 1'b1;
          m2r_d = 1'b1;
        end else begin
          mw_d = 1'b1;
        end
      end
      2'b10: begin
        br_d  = 1'b1;
        alu_d = FUNC_W'(1);
      end
      default: begin
        vec_d = 1'b1;
        if (!Opcode[0]) begin
          rwv_d = 1'b1;
          alu_d = Func;
        end else begin
          mw_d     = 1'b1;
          alusrc_d = 1'b1;
        end
      end
    endcase
  end

  assign pcsrc_d       = br_d | (rw_d & (Rd == REG_W'(PC_REG)));
  assign unused_opcode = ^Opcode;

  // Out-of-range vector lengths fall back to a full vector.
`ifdef VEC_TAIL_MASK_EN
  always_comb begin
    vlen_d = vlen;
    if ((vlen == '0) || (int'(vlen) > VEC_ELEMS)) begin
      vlen_d = VLW'(VEC_ELEMS);
    end
  end
`else
  assign vlen_d = VLW'(VEC_ELEMS);
`endif

  assign last_d   = vec_d ? last_beat_of(int'(vlen_d)) : '0;
  assign beat_d   = beat_q + BW'(1);
  assign in_ready = !stall && (rst || (state_q == IDLE) || (beat_q == last_q));
  assign accept   = in_valid && in_ready && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      last_q        <= '0;
      vlen_q        <= '0;
      out_valid_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_write_v_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      alu_src_q     <= 1'b0;
      branch_q      <= 1'b0;
      pc_src_q      <= 1'b0;
      alu_ctrl_q    <= '0;
      beat_idx_q    <= '0;
      last_beat_q   <= 1'b0;
      lane_mask_q   <= '0;
      busy_q        <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        out_valid_q   <= 1'b1;
        reg_write_q   <= rw_d;
        reg_write_v_q <= rwv_d;
        mem_write_q   <= mw_d;
        mem_to_reg_q  <= m2r_d;
        alu_src_q     <= alusrc_d;
        branch_q      <= br_d;
        pc_src_q      <= pcsrc_d;
        alu_ctrl_q    <= alu_d;
        beat_q        <= '0;
        beat_idx_q    <= '0;
        last_q        <= last_d;
        last_beat_q   <= (last_d == '0);
        lane_mask_q   <= vec_d ? lane_mask(0, int'(vlen_d)) : '1;
        if (vec_d) begin
          vlen_q <= vlen_d;
        end
        // A single-beat vector op issues like a scalar and never enters VSEQ.
        if (last_d != '0) begin
          state_q <= VSEQ;
          busy_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if ((state_q == VSEQ) && (beat_q != last_q)) begin
        out_valid_q <= 1'b1;
        beat_q      <= beat_d;
        beat_idx_q  <= beat_d;
        last_beat_q <= (beat_d == last_q);
        lane_mask_q <= lane_mask(int'(beat_d), int'(vlen_q));
      end else begin
        state_q     <= IDLE;
        beat_q      <= '0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign RegWrite   = reg_write_q;
  assign RegWriteV  = reg_write_v_q;
  assign MemWrite   = mem_write_q;
  assign MemtoReg   = mem_to_reg_q;
  assign ALUSrc     = alu_src_q;
  assign Branch     = branch_q;
  assign PCSrc      = pc_src_q;
  assign ALUControl = alu_ctrl_q;
  assign BeatIdx    = beat_idx_q;
  assign LastBeat   = last_beat_q;
  assign LaneMask   = lane_mask_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_control_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_vector_control_sequencer: directed plus random checks of the          |
// | sequencer against a beat-queue reference model.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_vector_control_sequencer;

  localparam int LANES     = 4;
  localparam int VEC_ELEMS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] Opcode;
  logic [2:0] Func;
  logic [4:0] Rd;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic       RegWrite, RegWriteV, MemWrite, MemtoReg, ALUSrc, Branch, PCSrc;
  logic [2:0] ALUControl;
  logic [1:0] BeatIdx;
  logic       LastBeat;
  logic [3:0] LaneMask;
  logic       busy;
`ifdef VEC_TAIL_MASK_EN
  logic [4:0] vlen;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_control_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Opcode     (Opcode),
    .Func       (Func),
    .Rd         (Rd),
`ifdef VEC_TAIL_MASK_EN
    .vlen       (vlen),
`endif
    .stall      (stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .RegWrite   (RegWrite),
    .RegWriteV  (RegWriteV),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .Branch     (Branch),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .BeatIdx    (BeatIdx),
    .LastBeat   (LastBeat),
    .LaneMask   (LaneMask),
    .busy       (busy)
  );

  // One entry per output beat still to be emitted by the current instruction.
  typedef struct {
    bit       valid, rw, rwv, mw, m2r, alusrc, br, pcs, last, busy;
    bit [2:0] alu;
    bit [1:0] beat;
    bit [3:0] mask;
  } exp_t;

  exp_t cur;
  exp_t pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_instr(input logic [5:0] op, input logic [2:0] fn,
                                     input logic [4:0] rd, input int len);
    exp_t e;
    int   n;
    bit   vec;
    e   = '{default: 0};
    vec = (op[5:4] == 2'b11);
    case (op[5:4])
      2'b00: begin e.rw = 1; e.alu = fn; end
      2'b01: if (op[0] == 1'b0) begin e.rw = 1; e.m2r = 1; e.alusrc = 1; end
             else begin e.mw = 1; e.alusrc = 1; end
      2'b10: begin e.br = 1; e.alu = 3'b001; end
      default: if (op[0] == 1'b0) begin e.rwv = 1; e.alu = fn; end
               else begin e.mw = 1; e.alusrc = 1; end
    endcase
    e.pcs = e.br | (e.rw && (rd == 5'd15));
    n = vec ? (len + LANES - 1) / LANES : 1;
    for (int k = 0; k < n; k++) begin
      e.valid = 1;
      e.beat  = 2'(k);
      e.last  = (k == n - 1);
      e.busy  = vec && (n > 1);
      for (int l = 0; l < LANES; l++) e.mask[l] = vec ? ((k * LANES + l) < len) : 1'b1;
      pend.push_back(e);
    end
  endfunction

  // Check outputs at the falling edge, then advance the model across the rising edge.
  task automatic step();
    bit rdy;
    int len;
    @(negedge clk);
    rdy = !stall && (rst || (pend.size() == 0));
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, cur.valid);
    chk("busy", busy, cur.busy);
    if (cur.valid) begin
      chk("RegWrite", RegWrite, cur.rw);
      chk("RegWriteV", RegWriteV, cur.rwv);
      chk("MemWrite", MemWrite, cur.mw);
      chk("MemtoReg", MemtoReg, cur.m2r);
      chk("ALUSrc", ALUSrc, cur.alusrc);
      chk("Branch", Branch, cur.br);
      chk("PCSrc", PCSrc, cur.pcs);
      chk("ALUControl", ALUControl, cur.alu);
      chk("BeatIdx", BeatIdx, cur.beat);
      chk("LastBeat", LastBeat, cur.last);
      chk("LaneMask", LaneMask, cur.mask);
    end
    len = VEC_ELEMS;
`ifdef VEC_TAIL_MASK_EN
    if ((vlen != 0) && (vlen <= VEC_ELEMS)) len = vlen;
`endif
    if (rst) begin
      pend.delete();
      cur = '{default: 0};
    end else if (flush) begin
      pend.delete();
      cur.valid = 0;
      cur.busy  = 0;
    end else if (!stall) begin
      if (in_valid && rdy) push_instr(Opcode, Func, Rd, len);
      if (pend.size() > 0) cur = pend.pop_front();
      else begin
        cur.valid = 0;
        cur.busy  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] op, input logic [2:0] fn,
                        input logic [4:0] rd);
    in_valid = v;
    Opcode   = op;
    Func     = fn;
    Rd       = rd;
  endtask

  initial begin
    int vcnt;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
`ifdef VEC_TAIL_MASK_EN
    vlen = 5'd0;
`endif
    cur = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", {RegWrite, RegWriteV, MemWrite, MemtoReg, ALUSrc, Branch, PCSrc}, 0);
    chk("rst_alu", ALUControl, 0);
    chk("rst_beat", {BeatIdx, LastBeat, LaneMask}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Scalar ALU, then the same with Rd aliasing the PC
    set_in(1'b1, 6'b000000, 3'b010, 5'd3); step();
    chk("alu_valid", out_valid, 1);
    chk("alu_regwrite", RegWrite, 1);
    chk("alu_ctrl", ALUControl, 3'b010);
    chk("alu_pcsrc", PCSrc, 0);
    chk("alu_last", LastBeat, 1);
    set_in(1'b1, 6'b000000, 3'b010, 5'd15); step();
    chk("alu_pc_pcsrc", PCSrc, 1);
    set_in(1'b0, 6'd0, 3'd0, 5'd0); step();
    chk("idle_valid", out_valid, 0);

    // Full vector: four beats
    set_in(1'b1, 6'b110000, 3'b100, 5'd1); step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    for (int b = 0; b < 4; b++) begin
      chk("vec_beat", BeatIdx, b);
      chk("vec_rwv", RegWriteV, 1);
      chk("vec_last", LastBeat, (b == 3));
      chk("vec_ready", in_ready, (b == 3));
      step();
    end

    // Stall on beat 1 for three cycles
    set_in(1'b1, 6'b110010, 3'b011, 5'd2); step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    vcnt = out_valid;
    step(); vcnt += out_valid;
    stall = 1'b1;
    repeat (3) begin
      step(); vcnt += out_valid;
      chk("stall_hold_beat", BeatIdx, 1);
    end
    stall = 1'b0;
    repeat (3) begin step(); vcnt += out_valid; end
    chk("stall_valid_cycles", vcnt, 7);

    // Flush during beat 2 of a vector store, then a scalar load
    set_in(1'b1, 6'b110001, 3'b000, 5'd0); step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    step(); step();
    chk("flush_pre_beat", BeatIdx, 2);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_ready", in_ready, 1);
    set_in(1'b1, 6'b010000, 3'b111, 5'd4); step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    chk("load_valid", out_valid, 1);
    chk("load_memtoreg", MemtoReg, 1);
    chk("load_alu", ALUControl, 0);
    step();

    // Back-to-back vector then branch
    set_in(1'b1, 6'b110000, 3'b101, 5'd0); step();
    set_in(1'b1, 6'b100000, 3'b110, 5'd0);
    repeat (3) step();
    chk("b2b_beat3", BeatIdx, 3);
    chk("b2b_ready", in_ready, 1);
    step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_branch", Branch, 1);
    chk("b2b_pcsrc", PCSrc, 1);
    chk("b2b_alu", ALUControl, 3'b001);
    step();

`ifdef VEC_TAIL_MASK_EN
    vlen = 5'd6;
    set_in(1'b1, 6'b110000, 3'b001, 5'd0); step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    chk("tail_mask0", LaneMask, 4'b1111);
    chk("tail_last0", LastBeat, 0);
    step();
    chk("tail_mask1", LaneMask, 4'b0011);
    chk("tail_last1", LastBeat, 1);
    step();
    chk("tail_done", out_valid, 0);
    vlen = 5'd0;
    set_in(1'b1, 6'b110000, 3'b001, 5'd0); step();
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    for (int b = 0; b < 4; b++) begin
      chk("vlen0_mask", LaneMask, 4'b1111);
      chk("vlen0_beat", BeatIdx, b);
      step();
    end
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1);
      Opcode   = 6'($urandom);
      Func     = 3'($urandom);
      Rd       = ($urandom_range(0, 3) == 0) ? 5'd15 : 5'($urandom);
`ifdef VEC_TAIL_MASK_EN
      vlen     = 5'($urandom);
`endif
      step();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 6'd0, 3'd0, 5'd0);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vector_control_sequencer.md
Name: vector_control_sequencer

Overview:
- Parametrised, sequential successor to the single-cycle control unit.
- Accepts one decoded-instruction field set per handshake and produces registered pipeline control signals.
- Vector instructions expand into a multi-beat sequence: VEC_ELEMS elements processed LANES at a time, with beat index and lane mask.
- Sits between the fetch/decode register and the execute stage; supports stall and flush.

Parameters:
- OPCODE_W, 6, opcode field width.
- FUNC_W, 3, function field width; also the ALUControl width.
- REG_W, 5, register index width.
- PC_REG, 15, register index that aliases the PC (a write to it forces PCSrc).
- LANES, 4, vector lanes processed per beat.
- VEC_ELEMS, 16, elements per vector instruction. Must be a multiple of LANES. BEATS = VEC_ELEMS/LANES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  sequencer can accept this cycle.
- Opcode  in  OPCODE_W  opcode.
- Func  in  FUNC_W  function field.
- Rd  in  REG_W  destination register.
- stall  in  1  hold all outputs and state.
- flush  in  1  abort current sequence, kill output.
- out_valid  out  1  control bundle valid.
- RegWrite, RegWriteV, MemWrite, MemtoReg, ALUSrc, Branch, PCSrc  out  1 each  control signals.
- ALUControl  out  FUNC_W  ALU operation.
- BeatIdx  out  max(1,$clog2(BEATS))  current beat, 0 for scalar.
- LastBeat  out  1  final beat of a vector op; 1 for scalar.
- LaneMask  out  LANES  lane enables, all ones for scalar.
- busy  out  1  vector sequence in progress.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high. In reset, all outputs are 0, except in_ready = !stall. State = IDLE, beat counter = 0.
- Decode by Opcode[5:4]:
  - 00 scalar ALU: RegWrite=1, ALUControl=Func.
  - 01 scalar memory:
    - Opcode[0]=0 load: RegWrite=1, MemtoReg=1, ALUSrc=1, ALUControl=0.
    - Opcode[0]=1 store: MemWrite=1, ALUSrc=1, ALUControl=0.
  - 10 branch: Branch=1, ALUControl=3'b001.
  - 11 vector:
    - Opcode[0]=0: RegWriteV=1, ALUControl=Func.
    - Opcode[0]=1 vector store: MemWrite=1, ALUSrc=1, ALUControl=0.
  - Unlisted signals are 0. PCSrc = Branch | (RegWrite & Rd==PC_REG).
- States: IDLE, VSEQ.
- Handshake:
  - Accept = in_valid & in_ready & !flush.
  - in_ready = !stall & (IDLE | (VSEQ & last beat)).
- Latency: outputs are registered and appear 1 cycle after accept.
- Scalar accept: out_valid=1 for one cycle, BeatIdx=0, LastBeat=1, LaneMask all ones. State stays IDLE.
- Vector accept:
  - State moves to VSEQ and the decoded bundle is latched.
  - Each non-stalled cycle emits one beat (BeatIdx 0..n-1, out_valid=1); LastBeat=1 on beat n-1.
  - n = BEATS; see the optional feature.
  - After the last beat: back to IDLE, or straight into a new instruction if one is accepted the same cycle (back-to-back, no bubble).
  - busy=1 from the cycle after accept through the last beat.
- With no accept and no active sequence, out_valid=0 next cycle. Other outputs hold their last values.
- stall=1: every register holds, including out_valid. No accept.
- flush=1 (priority over stall and accept): next cycle out_valid=0, busy=0, state IDLE, beat 0. The same-cycle input is dropped.
- Reset mid-sequence: identical to flush, plus all outputs cleared.
- BEATS=1 is legal: a vector op behaves as a single-beat issue with busy staying 0.

Optional Feature:
- Macro: VEC_TAIL_MASK_EN.
- When defined:
  - Extra input vlen, width $clog2(VEC_ELEMS+1), captured on vector accept. vlen=0 or vlen>VEC_ELEMS is treated as VEC_ELEMS.
  - Number of beats n = ceil(vlen/LANES).
  - LaneMask[l] on beat b = (b*LANES + l < vlen).
- When undefined: no vlen port, n = BEATS, LaneMask all ones.

Test Plan:
- Reset, then scalar ALU Opcode=6'b000000, Func=3'b010, Rd=3 -> one cycle later out_valid=1, RegWrite=1, ALUControl=010, PCSrc=0, LastBeat=1. Repeat with Rd=15 -> PCSrc=1.
- Vector Opcode=6'b110000, Func=3'b100 with LANES=4, VEC_ELEMS=16 -> 4 consecutive beats: BeatIdx 0,1,2,3, RegWriteV=1, LastBeat only on beat 3, in_ready=0 on beats 0-2.
- Vector op with stall=1 asserted on beat 1 for 3 cycles -> BeatIdx holds at 1 for 4 cycles total, then 2,3. Total 7 valid cycles.
- Flush during beat 2 of a vector store -> next cycle out_valid=0, busy=0, in_ready=1. A subsequent scalar load issues normally with MemtoReg=1.
- Back-to-back: vector, then branch presented while beat 3 is output -> branch out_valid the cycle after beat 3, Branch=1, PCSrc=1, ALUControl=001, no bubble.
- VEC_TAIL_MASK_EN with vlen=6 -> 2 beats, LaneMask 1111 then 0011. vlen=0 -> 4 beats, all 1111.
